// File: rtl/vfpu_cfg_master_pkg.sv
// Shared definitions for the VFPU configuration master: HWPE register map,
// acquire sentinel and the state encodings of both FSMs.
package vfpu_cfg_package;

    localparam logic [31:0] TRIGGER      = 32'h0000_0000;
    localparam logic [31:0] ACQUIRE      = 32'h0000_0004;
    localparam logic [31:0] STATUS       = 32'h0000_000C;
    localparam logic [31:0] PARAM_BASE   = 32'h0000_0040;
    localparam logic [31:0] ACQUIRE_BUSY = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACQ,
        S_BACKOFF,
        S_WR_PARAM,
        S_TRIGGER,
        S_POLL_WAIT,
        S_POLL,
        S_DONE
    } cfg_state_e;

    typedef enum logic [1:0] {
        TXN_IDLE,
        TXN_REQ,
        TXN_RESP
    } txn_state_e;

    function automatic logic [31:0] param_addr(input logic [31:0] idx);
        return PARAM_BASE + (idx << 2);
    endfunction

endpackage

// File: rtl/vfpu_cfg_master_if.sv
// Peripheral bus between the configuration master and the HWPE slave port.
interface vfpu_cfg_master_if #(
    parameter int ID_WIDTH = 16
);
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );

    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/vfpu_cfg_master_periph_txn.sv
// One peripheral-bus transaction at a time: request held until grant, then
// wait for the response and hand its data back with a one-cycle done pulse.
module vfpu_periph_txn
    import vfpu_cfg_package::*;
#(
    parameter int          ID_WIDTH = 16,
    parameter int unsigned ID_VALUE = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    vfpu_cfg_master_if.master periph
);

    txn_state_e state;

    // Responses carry no routing information we need; the id is not checked.
    logic unused_rid;
    assign unused_rid = ^periph.r_id;

    assign periph.id = ID_WIDTH'(ID_VALUE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= TXN_IDLE;
            periph.req  <= 1'b0;
            periph.add  <= '0;
            periph.wen  <= 1'b0;
            periph.be   <= '0;
            periph.data <= '0;
            done        <= 1'b0;
            rdata       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                TXN_IDLE: begin
                    if (start) begin
                        periph.req  <= 1'b1;
                        periph.add  <= addr;
                        periph.wen  <= wen;
                        periph.be   <= 4'hF;
                        periph.data <= wdata;
                        state       <= TXN_REQ;
                    end
                end
                TXN_REQ: begin
                    if (periph.gnt) begin
                        periph.req <= 1'b0;
                        state      <= TXN_RESP;
                    end
                end
                TXN_RESP: begin
                    // Writes also wait here so only one transaction is ever open.
                    if (periph.r_valid) begin
                        done  <= 1'b1;
                        rdata <= periph.r_data;
                        state <= TXN_IDLE;
                    end
                end
                default: state <= TXN_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/vfpu_cfg_master.sv
// Programs and launches one VFPU HWPE job: acquire a slot, write the
// parameter registers, trigger, then poll status until the engine is idle.
module vfpu_cfg_master
    import vfpu_cfg_package::*;
#(
    parameter int          NB_PARAMS      = 13,
    parameter int          ID_WIDTH       = 16,
    parameter int unsigned ID_VALUE       = 0,
    parameter int          BACKOFF_CYCLES = 8,
    parameter int          POLL_GAP       = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   job_valid_i,
    output logic                   job_ready_o,
    input  logic [32*NB_PARAMS-1:0] job_params_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [7:0]             job_id_o,
    vfpu_cfg_master_if.master      periph
);

    localparam int IDX_W   = (NB_PARAMS > 1) ? $clog2(NB_PARAMS) : 1;
    localparam int CNT_MAX = (BACKOFF_CYCLES > POLL_GAP) ? BACKOFF_CYCLES : POLL_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    cfg_state_e                  state;
    logic [NB_PARAMS-1:0][31:0]  params_q;
    logic [IDX_W-1:0]            idx;
    logic [CNT_W-1:0]            cnt;
    logic                        pending;
    logic                        txn_start;
    logic [31:0]                 txn_addr;
    logic                        txn_wen;
    logic [31:0]                 txn_wdata;
    logic                        txn_done;
    logic [31:0]                 txn_rdata;

    vfpu_periph_txn #(
        .ID_WIDTH (ID_WIDTH),
        .ID_VALUE (ID_VALUE)
    ) u_txn (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start  (txn_start),
        .addr   (txn_addr),
        .wen    (txn_wen),
        .wdata  (txn_wdata),
        .done   (txn_done),
        .rdata  (txn_rdata),
        .periph (periph)
    );

    // Each bus state issues its transaction on entry (pending=0) and then
    // waits for the matching done before deciding where to go next.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            job_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            job_id_o    <= '0;
            params_q    <= '0;
            idx         <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            txn_start   <= 1'b0;
            txn_addr    <= '0;
            txn_wen     <= 1'b0;
            txn_wdata   <= '0;
        end else begin
            txn_start <= 1'b0;
            done_o    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (job_valid_i) begin
                        params_q    <= job_params_i;
                        busy_o      <= 1'b1;
                        job_ready_o <= 1'b0;
                        state       <= S_ACQ;
                    end
                end
                S_ACQ: begin
                    if (!pending) begin
                        txn_start <= 1'b1;
                        txn_addr  <= ACQUIRE;
                        txn_wen   <= 1'b1;
                        txn_wdata <= '0;
                        pending   <= 1'b1;
                    end else if (txn_done) begin
                        pending <= 1'b0;
                        if (txn_rdata == ACQUIRE_BUSY) begin
                            cnt   <= '0;
                            state <= S_BACKOFF;
                        end else begin
                            job_id_o <= txn_rdata[7:0];
                            idx      <= '0;
                            state    <= S_WR_PARAM;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (cnt == CNT_W'(BACKOFF_CYCLES - 1)) begin
                        cnt   <= '0;
                        state <= S_ACQ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_WR_PARAM: begin
                    if (!pending) begin
                        txn_start <= 1'b1;
                        txn_addr  <= param_addr(32'(idx));
                        txn_wen   <= 1'b0;
                        txn_wdata <= params_q[idx];
                        pending   <= 1'b1;
                    end else if (txn_done) begin
                        pending <= 1'b0;
                        if (idx == IDX_W'(NB_PARAMS - 1)) state <= S_TRIGGER;
                        else                              idx   <= idx + IDX_W'(1);
                    end
                end
                S_TRIGGER: begin
                    if (!pending) begin
                        txn_start <= 1'b1;
                        txn_addr  <= TRIGGER;
                        txn_wen   <= 1'b0;
                        txn_wdata <= '0;
                        pending   <= 1'b1;
                    end else if (txn_done) begin
                        pending <= 1'b0;
                        cnt     <= '0;
                        state   <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (cnt == CNT_W'(POLL_GAP - 1)) begin
                        cnt   <= '0;
                        state <= S_POLL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_POLL: begin
                    if (!pending) begin
                        txn_start <= 1'b1;
                        txn_addr  <= STATUS;
                        txn_wen   <= 1'b1;
                        txn_wdata <= '0;
                        pending   <= 1'b1;
                    end else if (txn_done) begin
                        pending <= 1'b0;
                        if (txn_rdata == '0) begin
                            done_o <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            cnt   <= '0;
                            state <= S_POLL_WAIT;
                        end
                    end
                end
                S_DONE: begin
                    busy_o      <= 1'b0;
                    job_ready_o <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
